chaos_tracker: RTL and testbench

Sits between `mercer_engine` and `scoreboard`. It accepts interference commands for one of four valet queues and holds one outstanding chaos event per queue. It measures the cycles until that queue acknowledges recovery, or until the event times out. It then serialises the outcomes into the single-event pulse and latency stream that `scoreboard` accumulates.

---
 rtl/chaos_pkg.sv | 29 ++
 rtl/chaos_tracker_if.sv | 29 ++
 rtl/chaos_queue_slot.sv | 87 ++++++++
 rtl/chaos_tracker.sv | 102 ++++++++++
 tb/tb_chaos_tracker.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chaos_pkg.sv
// Shared types and constants for the chaos_tracker slice: opcodes, slot states, widths.
package chaos_pkg;

    localparam int NUM_QUEUES = 4;
    localparam int QID_W      = $clog2(NUM_QUEUES);
    localparam int LAT_W      = 16;
    localparam int TAG_W      = 16;
    localparam int OPC_W      = 4;
    localparam int REJ_W      = 8;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP      = 4'd0,
        OP_STALL    = 4'd1,
        OP_DROP_REQ = 4'd2,
        OP_CORRUPT  = 4'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_DONE    = 2'd2
    } slot_state_e;

    // Reserved opcodes 4..15 behave exactly like NOP.
    function automatic logic is_chaos_cmd(input logic [OPC_W-1:0] op);
        return (op == OP_STALL) || (op == OP_DROP_REQ) || (op == OP_CORRUPT);
    endfunction

endpackage

// File: rtl/chaos_tracker_if.sv
// Command/ack bus from mercer_engine and report stream towards scoreboard.
interface chaos_tracker_if;
    import chaos_pkg::*;

    logic [OPC_W-1:0]      interference_opcode;
    logic [QID_W-1:0]      target_queue_id;
    logic [TAG_W-1:0]      injected_tag;
    logic [NUM_QUEUES-1:0] queue_ack;
    logic [TAG_W-1:0]      ack_tag;
    logic                  chaos_event;
    logic                  stall_trigger;
    logic                  chaos_recovered;
    logic                  drop_trigger;
    logic [LAT_W-1:0]      return_latency;
    logic [REJ_W-1:0]      rejected_count;

    modport master (
        output interference_opcode, target_queue_id, injected_tag, queue_ack, ack_tag,
        input  chaos_event, stall_trigger, chaos_recovered, drop_trigger,
               return_latency, rejected_count
    );

    modport slave (
        input  interference_opcode, target_queue_id, injected_tag, queue_ack, ack_tag,
        output chaos_event, stall_trigger, chaos_recovered, drop_trigger,
               return_latency, rejected_count
    );

endinterface

// File: rtl/chaos_queue_slot.sv
// One outstanding chaos event: IDLE/PENDING/DONE FSM, age counter, stored tag, latched result.
module chaos_queue_slot
    import chaos_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [TAG_W-1:0]  cmd_tag,
    input  logic              ack,
    input  logic [TAG_W-1:0]  ack_tag,
    input  logic              release_en,
    output slot_state_e       state,
    output logic [LAT_W-1:0]  latency,
    output logic              dropped
);

    localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);

    slot_state_e      state_q, state_d;
    logic [LAT_W-1:0] age_q, age_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             drop_q, drop_d;
    logic             ack_hit;

    assign ack_hit = ack && (ack_tag == tag_q);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            age_q   <= '0;
            tag_q   <= '0;
            lat_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            age_q   <= age_d;
            tag_q   <= tag_d;
            lat_q   <= lat_d;
            drop_q  <= drop_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        age_d   = age_q;
        tag_d   = tag_q;
        lat_d   = lat_q;
        drop_d  = drop_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_PENDING;
                    tag_d   = cmd_tag;
                    age_d   = LAT_W'(1);
                end
            end
            ST_PENDING: begin
                // A matching ack beats a timeout landing on the same edge.
                if (ack_hit) begin
                    state_d = ST_DONE;
                    lat_d   = age_q;
                    drop_d  = 1'b0;
                end else if (age_q == TIMEOUT_L) begin
                    state_d = ST_DONE;
                    lat_d   = TIMEOUT_L;
                    drop_d  = 1'b1;
                end else begin
                    age_d = age_q + LAT_W'(1);
                end
            end
            ST_DONE: begin
                if (release_en) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign state   = state_q;
    assign latency = lat_q;
    assign dropped = drop_q;

endmodule

// File: rtl/chaos_tracker.sv
// Tracks one chaos event per valet queue and serialises recoveries/timeouts for scoreboard.
// Optional feature: define CHAOS_TRACKER_REJECT_CNT_EN to enable the rejected-command counter.
module chaos_tracker
    import chaos_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            rst,
    chaos_tracker_if.slave  bus
);

    slot_state_e           slot_state [NUM_QUEUES];
    logic [LAT_W-1:0]      slot_lat   [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] slot_drop;
    logic [NUM_QUEUES-1:0] accept;
    logic [NUM_QUEUES-1:0] release_vec;
    logic                  cmd_valid;
    logic                  target_idle;
    logic                  rpt_valid;
    logic [QID_W-1:0]      rpt_sel;

    logic                  event_q, stall_q, recovered_q, drop_q;
    logic [LAT_W-1:0]      latency_q;

    // A PENDING or DONE target (including one being released this cycle) refuses the command.
    assign cmd_valid   = is_chaos_cmd(bus.interference_opcode);
    assign target_idle = (slot_state[bus.target_queue_id] == ST_IDLE);

    always_comb begin
        accept = '0;
        accept[bus.target_queue_id] = cmd_valid && target_idle;
    end

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_slot
        chaos_queue_slot #(.TIMEOUT(TIMEOUT)) u_slot (
            .clk        (clk),
            .rst        (rst),
            .accept     (accept[i]),
            .cmd_tag    (bus.injected_tag),
            .ack        (bus.queue_ack[i]),
            .ack_tag    (bus.ack_tag),
            .release_en (release_vec[i]),
            .state      (slot_state[i]),
            .latency    (slot_lat[i]),
            .dropped    (slot_drop[i])
        );
    end

    // Fixed priority: scanning downwards leaves the lowest-index DONE slot selected.
    always_comb begin
        rpt_valid   = 1'b0;
        rpt_sel     = '0;
        release_vec = '0;
        for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
            if (slot_state[i] == ST_DONE) begin
                rpt_valid = 1'b1;
                rpt_sel   = QID_W'(i);
            end
        end
        release_vec[rpt_sel] = rpt_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            event_q     <= 1'b0;
            stall_q     <= 1'b0;
            recovered_q <= 1'b0;
            drop_q      <= 1'b0;
            latency_q   <= '0;
        end else begin
            event_q     <= cmd_valid && target_idle;
            stall_q     <= cmd_valid && target_idle && (bus.interference_opcode == OP_STALL);
            recovered_q <= rpt_valid && !slot_drop[rpt_sel];
            drop_q      <= rpt_valid && slot_drop[rpt_sel];
            if (rpt_valid) latency_q <= slot_lat[rpt_sel];
        end
    end

    assign bus.chaos_event     = event_q;
    assign bus.stall_trigger   = stall_q;
    assign bus.chaos_recovered = recovered_q;
    assign bus.drop_trigger    = drop_q;
    assign bus.return_latency  = latency_q;

`ifdef CHAOS_TRACKER_REJECT_CNT_EN
    logic [REJ_W-1:0] rej_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rej_q <= '0;
        end else if (cmd_valid && !target_idle && (rej_q != {REJ_W{1'b1}})) begin
            rej_q <= rej_q + REJ_W'(1);
        end
    end

    assign bus.rejected_count = rej_q;
`else
    assign bus.rejected_count = '0;
`endif

endmodule

// File: tb/tb_chaos_tracker.sv
// Directed bench for chaos_tracker with an event/report scoreboard; honours CHAOS_TRACKER_REJECT_CNT_EN.
module tb_chaos_tracker;
    import chaos_pkg::*;

    localparam int TO_SHORT = 8;
    localparam int TO_LONG  = 1024;

    typedef struct {
        logic stall;
        int   due;
    } ev_t;

    typedef struct {
        logic        drop;
        logic [15:0] lat;
        int          due;
    } rep_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opc;
    logic [1:0]  qid;
    logic [15:0] tag;
    logic [3:0]  ack;
    logic [15:0] atag;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exp_rej = 0;
    int   long_ev_cnt = 0;
    int   long_base;
    bit   mon_on = 1'b0;
    ev_t  ev_q[$];
    rep_t rep_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chaos_tracker_if bus ();
    chaos_tracker_if bus_l ();

    assign bus.interference_opcode   = opc;
    assign bus.target_queue_id       = qid;
    assign bus.injected_tag          = tag;
    assign bus.queue_ack             = ack;
    assign bus.ack_tag               = atag;
    assign bus_l.interference_opcode = opc;
    assign bus_l.target_queue_id     = qid;
    assign bus_l.injected_tag        = tag;
    assign bus_l.queue_ack           = ack;
    assign bus_l.ack_tag             = atag;

    chaos_tracker #(.TIMEOUT(TO_SHORT)) dut   (.clk(clk), .rst(rst), .bus(bus));
    chaos_tracker #(.TIMEOUT(TO_LONG))  dut_l (.clk(clk), .rst(rst), .bus(bus_l));

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic int rej_expected(input int n);
`ifdef CHAOS_TRACKER_REJECT_CNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic idle_inputs();
        opc = 4'd0; qid = 2'd0; tag = 16'd0; ack = 4'd0; atag = 16'd0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            idle_inputs();
        end
    endtask

    // Drives a command for the next edge and records what the bench expects of it.
    task automatic cmd(input logic [3:0] op, input logic [1:0] q, input logic [15:0] t,
                       input bit accepted);
        ev_t e;
        opc = op; qid = q; tag = t;
        if (accepted) begin
            e.stall = (op == 4'd1);
            e.due   = cyc + 1;
            ev_q.push_back(e);
        end else if (exp_rej < 255) begin
            exp_rej++;
        end
    endtask

    task automatic do_ack(input logic [3:0] mask, input logic [15:0] t);
        ack = mask; atag = t;
    endtask

    task automatic expect_report(input logic drop, input logic [15:0] lat, input int due);
        rep_t r;
        r.drop = drop; r.lat = lat; r.due = due;
        rep_q.push_back(r);
    endtask

    task automatic check_quiet(input string pfx);
        check({pfx, "_event"},     32'(bus.chaos_event), 0);
        check({pfx, "_stall"},     32'(bus.stall_trigger), 0);
        check({pfx, "_recovered"}, 32'(bus.chaos_recovered), 0);
        check({pfx, "_drop"},      32'(bus.drop_trigger), 0);
        check({pfx, "_latency"},   32'(bus.return_latency), 0);
        check({pfx, "_rejected"},  32'(bus.rejected_count), 0);
    endtask

    // Monitor: every pulse must match the next scoreboard entry, including the cycle it lands in.
    always @(negedge clk) begin
        if (bus_l.chaos_event) long_ev_cnt++;
        if (mon_on) begin
            if (bus.chaos_event) begin
                if (ev_q.size() == 0) begin
                    check("spurious_event", 32'(bus.chaos_event), 0);
                end else begin : pop_ev
                    ev_t e;
                    e = ev_q.pop_front();
                    check("event_stall", 32'(bus.stall_trigger), 32'(e.stall));
                    check("event_cycle", cyc, e.due);
                end
            end else if (bus.stall_trigger) begin
                check("stall_without_event", 32'(bus.stall_trigger), 0);
            end
            if (bus.chaos_recovered || bus.drop_trigger) begin
                if (rep_q.size() == 0) begin
                    check("spurious_report", {bus.chaos_recovered, bus.drop_trigger}, 0);
                end else begin : pop_rep
                    rep_t r;
                    r = rep_q.pop_front();
                    check("report_kind", {bus.chaos_recovered, bus.drop_trigger},
                          r.drop ? 32'd1 : 32'd2);
                    check("report_latency", 32'(bus.return_latency), 32'(r.lat));
                    check("report_cycle", cyc, r.due);
                end
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check_quiet("reset");
        mon_on = 1'b1;

        // STALL q2, ack after 5 edges.
        cmd(4'd1, 2'd2, 16'h00AA, 1'b1);
        tick();
        tick(4);
        do_ack(4'b0100, 16'h00AA);
        expect_report(1'b0, 16'd5, cyc + 2);
        tick();
        tick(3);

        // Minimum latency of 1.
        cmd(4'd2, 2'd2, 16'h0BEE, 1'b1);
        tick();
        do_ack(4'b0100, 16'h0BEE);
        expect_report(1'b0, 16'd1, cyc + 2);
        tick();
        tick(3);

        // Ack to an idle slot, then CORRUPT q1 with a mismatched ack: it times out.
        do_ack(4'b0010, 16'h1234);
        tick();
        cmd(4'd3, 2'd1, 16'h1234, 1'b1);
        expect_report(1'b1, 16'd8, cyc + 1 + TO_SHORT + 1);
        tick();
        tick(2);
        do_ack(4'b0010, 16'h1235);
        tick();
        tick(12);
        check("latency_hold", 32'(bus.return_latency), 32'd8);

        // Matching ack on the timeout edge is reported as a recovery.
        cmd(4'd1, 2'd1, 16'h7777, 1'b1);
        tick();
        tick(TO_SHORT - 1);
        do_ack(4'b0010, 16'h7777);
        expect_report(1'b0, 16'd8, cyc + 2);
        tick();
        tick(3);

        // q0 and q3 acked together: q0 first, q3 one cycle later.
        cmd(4'd1, 2'd0, 16'h0F0F, 1'b1);
        tick();
        cmd(4'd2, 2'd3, 16'h0F0F, 1'b1);
        tick();
        tick(2);
        do_ack(4'b1001, 16'h0F0F);
        expect_report(1'b0, 16'd4, cyc + 2);
        expect_report(1'b0, 16'd3, cyc + 3);
        tick();
        tick(4);

        // Ack plus command on one slot, then command during its release cycle.
        cmd(4'd1, 2'd2, 16'h2222, 1'b1);
        tick();
        tick();
        do_ack(4'b0100, 16'h2222);
        cmd(4'd3, 2'd2, 16'h3333, 1'b0);
        expect_report(1'b0, 16'd2, cyc + 2);
        tick();
        cmd(4'd1, 2'd2, 16'h4444, 1'b0);
        tick();
        cmd(4'd1, 2'd2, 16'h4444, 1'b1);
        tick();
        do_ack(4'b0100, 16'h4444);
        expect_report(1'b0, 16'd1, cyc + 2);
        tick();
        tick(3);
        check("rejected_after_collisions", 32'(bus.rejected_count), rej_expected(exp_rej));

        // Second command to a PENDING q0 is rejected; q0 then times out.
        cmd(4'd1, 2'd0, 16'h5555, 1'b1);
        expect_report(1'b1, 16'd8, cyc + 1 + TO_SHORT + 1);
        tick();
        cmd(4'd1, 2'd0, 16'h5556, 1'b0);
        tick();
        tick();
        check("rejected_pending", 32'(bus.rejected_count), rej_expected(exp_rej));
        tick(12);

        // Reserved and NOP opcode streams.
        for (int i = 0; i < 8; i++) begin
            opc = 4'd7; qid = 2'(i); tag = 16'(i);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            opc = 4'd0; qid = 2'(i); tag = 16'(i);
            tick();
        end
        tick(2);
        check("rejected_after_nop", 32'(bus.rejected_count), rej_expected(exp_rej));

        // Reset with q1 and q2 pending: nothing is reported afterwards.
        cmd(4'd1, 2'd1, 16'h0111, 1'b1);
        tick();
        cmd(4'd2, 2'd2, 16'h0222, 1'b1);
        tick();
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_rej = 0;
        check_quiet("reset_mid");
        tick(TO_SHORT + 7);
        do_ack(4'b0100, 16'h0222);
        tick();
        cmd(4'd1, 2'd1, 16'h0999, 1'b1);
        tick();
        tick();
        do_ack(4'b0010, 16'h0999);
        expect_report(1'b0, 16'd2, cyc + 2);
        tick();
        tick(4);
        check("events_left", ev_q.size(), 0);
        check("reports_left", rep_q.size(), 0);

        // Saturation on the long-timeout instance, where q0 stays pending throughout.
        mon_on = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        long_ev_cnt = 0;
        opc = 4'd1; qid = 2'd0; tag = 16'hABCD;
        tick();
        opc = 4'd1; qid = 2'd0; tag = 16'hABCE;
        tick();
        tick();
        long_base = long_ev_cnt;
        check("long_accept_events", long_base, 1);
        check("long_first_reject", 32'(bus_l.rejected_count), rej_expected(1));
        for (int i = 0; i < 299; i++) begin
            opc = 4'd1; qid = 2'd0; tag = 16'(i);
            tick();
        end
        tick(2);
        check("long_saturated", 32'(bus_l.rejected_count), rej_expected(255));
        check("long_no_events", long_ev_cnt - long_base, 0);

        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check_quiet("final_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
